// File: rtl/pipe_stage_regs.sv
// Pipeline register bank for the 5-stage MIPS core: fetch PC, IF/ID and
// ID/EX registers with stall/flush handling, per-stage valid bits and
// saturating stall/flush counters for performance debug.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 10,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic [31:0]       pcnextF,
  output logic [31:0]       pcF,
  input  logic [31:0]       instrF,
  input  logic [31:0]       pcplus4F,
  output logic [31:0]       instrD,
  output logic [31:0]       pcplus4D,
  output logic              validD,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [31:0]       rd1D,
  input  logic [31:0]       rd2D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [31:0]       signimmD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [31:0]       rd1E,
  output logic [31:0]       rd2E,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [31:0]       signimmE,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] cntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] cntMax = {CNT_W{1'b1}};

  // A flush in Decode only takes effect when Decode is not also stalled
  logic flushDApplied;
  assign flushDApplied = flushD & ~stallD;

  // Fetch PC: hold while fetch is stalled, otherwise take the fetch mux result
  always_ff @(posedge clk) begin
    if (reset) begin
      pcF <= RESET_PC;
    end else if (!stallF) begin
      pcF <= pcnextF;
    end
  end

  // IF/ID register: stall beats flush, flush inserts a NOP marked invalid
  always_ff @(posedge clk) begin
    if (reset) begin
      instrD   <= 32'h0;
      pcplus4D <= 32'h0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (flushD) begin
      instrD   <= 32'h0;
      pcplus4D <= 32'h0;
      validD   <= 1'b0;
    end else begin
      instrD   <= instrF;
      pcplus4D <= pcplus4F;
      validD   <= 1'b1;
    end
  end

  // ID/EX register: a bubble zeroes every field so specifiers never forward
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      ctrlE    <= '0;
      rd1E     <= 32'h0;
      rd2E     <= 32'h0;
      rsE      <= 5'h0;
      rtE      <= 5'h0;
      rdE      <= 5'h0;
      signimmE <= 32'h0;
      validE   <= 1'b0;
    end else begin
      ctrlE    <= ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      rsE      <= rsD;
      rtE      <= rtD;
      rdE      <= rdD;
      signimmE <= signimmD;
      validE   <= validD;
    end
  end

  // Stall-cycle counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stallF && (stall_cnt != cntMax)) begin
      stall_cnt <= stall_cnt + cntOne;
    end
  end

  // Flush-event counter, counts only flushes that actually cleared IF/ID
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (flushDApplied && (flush_cnt != cntMax)) begin
      flush_cnt <= flush_cnt + cntOne;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs, built with narrow
// 4-bit counters so saturation is reachable in a few cycles.
module tb_pipe_stage_regs;

  localparam int CTRL_W = 10;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              stallF, stallD, flushD, flushE;
  logic [31:0]       pcnextF, pcF, instrF, pcplus4F, instrD, pcplus4D;
  logic              validD, validE;
  logic [CTRL_W-1:0] ctrlD, ctrlE;
  logic [31:0]       rd1D, rd2D, signimmD, rd1E, rd2E, signimmE;
  logic [4:0]        rsD, rtD, rdD, rsE, rtE, rdE;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_regs #(
    .RESET_PC(32'h0000_0000),
    .CTRL_W  (CTRL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stallF   (stallF),
    .stallD   (stallD),
    .flushD   (flushD),
    .flushE   (flushE),
    .pcnextF  (pcnextF),
    .pcF      (pcF),
    .instrF   (instrF),
    .pcplus4F (pcplus4F),
    .instrD   (instrD),
    .pcplus4D (pcplus4D),
    .validD   (validD),
    .ctrlD    (ctrlD),
    .rd1D     (rd1D),
    .rd2D     (rd2D),
    .rsD      (rsD),
    .rtD      (rtD),
    .rdD      (rdD),
    .signimmD (signimmD),
    .ctrlE    (ctrlE),
    .rd1E     (rd1E),
    .rd2E     (rd2E),
    .rsE      (rsE),
    .rtE      (rtE),
    .rdE      (rdE),
    .signimmE (signimmE),
    .validE   (validE),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive the hazard-unit controls and fetch-side inputs for the next edge
  task automatic applyStimulus(input logic rst, input logic sF, input logic sD,
                               input logic fD, input logic fE,
                               input logic [31:0] pcNext, input logic [31:0] instr,
                               input logic [31:0] pcPlus4);
    reset    = rst;
    stallF   = sF;
    stallD   = sD;
    flushD   = fD;
    flushE   = fE;
    pcnextF  = pcNext;
    instrF   = instr;
    pcplus4F = pcPlus4;
  endtask

  // Advance one rising edge and settle before sampling
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    ctrlD    = 10'h2A5;
    rd1D     = 32'h0000_0011;
    rd2D     = 32'h0000_0022;
    rsD      = 5'd3;
    rtD      = 5'd8;
    rdD      = 5'd9;
    signimmD = 32'h0000_0005;

    // Reset for two cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("rst_pcF",      pcF,       32'h0);
    checkOutput("rst_instrD",   instrD,    32'h0);
    checkOutput("rst_pcplus4D", pcplus4D,  32'h0);
    checkOutput("rst_validD",   {31'b0, validD}, 32'h0);
    checkOutput("rst_validE",   {31'b0, validE}, 32'h0);
    checkOutput("rst_ctrlE",    {22'b0, ctrlE},  32'h0);
    checkOutput("rst_stallcnt", {28'b0, stall_cnt}, 32'h0);
    checkOutput("rst_flushcnt", {28'b0, flush_cnt}, 32'h0);

    // Free run: first instruction enters Decode
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h2008_0005, 32'h4);
    stepCycle();
    checkOutput("run1_pcF",      pcF,      32'h4);
    checkOutput("run1_instrD",   instrD,   32'h2008_0005);
    checkOutput("run1_pcplus4D", pcplus4D, 32'h4);
    checkOutput("run1_validD",   {31'b0, validD}, 32'h1);
    checkOutput("run1_validE",   {31'b0, validE}, 32'h0);

    // Second instruction (a load) enters Decode, first moves to Execute
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h8C08_0000, 32'h8);
    stepCycle();
    checkOutput("run2_pcF",      pcF,      32'h8);
    checkOutput("run2_instrD",   instrD,   32'h8C08_0000);
    checkOutput("run2_validE",   {31'b0, validE}, 32'h1);
    checkOutput("run2_ctrlE",    {22'b0, ctrlE},  32'h2A5);
    checkOutput("run2_rd1E",     rd1E,     32'h11);
    checkOutput("run2_rd2E",     rd2E,     32'h22);
    checkOutput("run2_rsE",      {27'b0, rsE}, 32'd3);
    checkOutput("run2_rtE",      {27'b0, rtE}, 32'd8);
    checkOutput("run2_rdE",      {27'b0, rdE}, 32'd9);
    checkOutput("run2_signimmE", signimmE, 32'h5);

    // Load-use stall with bubble into Execute
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC, 32'hAAAA_AAAA, 32'hC);
    stepCycle();
    checkOutput("lu_pcF",      pcF,    32'h8);
    checkOutput("lu_instrD",   instrD, 32'h8C08_0000);
    checkOutput("lu_validD",   {31'b0, validD}, 32'h1);
    checkOutput("lu_validE",   {31'b0, validE}, 32'h0);
    checkOutput("lu_ctrlE",    {22'b0, ctrlE},  32'h0);
    checkOutput("lu_rsE",      {27'b0, rsE},    32'h0);
    checkOutput("lu_rtE",      {27'b0, rtE},    32'h0);
    checkOutput("lu_rd1E",     rd1E,   32'h0);
    checkOutput("lu_stallcnt", {28'b0, stall_cnt}, 32'h1);

    // Taken branch flushes Decode
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 32'h10);
    stepCycle();
    checkOutput("br_pcF",      pcF,      32'h40);
    checkOutput("br_instrD",   instrD,   32'h0);
    checkOutput("br_pcplus4D", pcplus4D, 32'h0);
    checkOutput("br_validD",   {31'b0, validD}, 32'h0);
    checkOutput("br_validE",   {31'b0, validE}, 32'h1);
    checkOutput("br_flushcnt", {28'b0, flush_cnt}, 32'h1);
    checkOutput("br_stallcnt", {28'b0, stall_cnt}, 32'h1);

    // Branch target fetched; the flushed slot reaches Execute as invalid
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0122_4020, 32'h44);
    stepCycle();
    checkOutput("tgt_instrD", instrD, 32'h0122_4020);
    checkOutput("tgt_validD", {31'b0, validD}, 32'h1);
    checkOutput("tgt_validE", {31'b0, validE}, 32'h0);

    // Stall and flush together: stall wins, nothing flushed or counted
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h48, 32'hFFFF_FFFF, 32'h48);
    stepCycle();
    checkOutput("sf_pcF",      pcF,      32'h48);
    checkOutput("sf_instrD",   instrD,   32'h0122_4020);
    checkOutput("sf_pcplus4D", pcplus4D, 32'h44);
    checkOutput("sf_validD",   {31'b0, validD}, 32'h1);
    checkOutput("sf_flushcnt", {28'b0, flush_cnt}, 32'h1);

    // Long fetch stall: counter climbs from 1 and sticks at all-ones
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h4C);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (i == 12) checkOutput("sat_stall_E", {28'b0, stall_cnt}, 32'hE);
      if (i == 13) checkOutput("sat_stall_F", {28'b0, stall_cnt}, 32'hF);
    end
    checkOutput("sat_stall_end", {28'b0, stall_cnt}, 32'hF);
    checkOutput("sat_pcF_held",  pcF, 32'h48);

    // Repeated flushes saturate the flush counter as well
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 32'h60);
    for (int i = 0; i < 16; i++) begin
      stepCycle();
      if (i == 12) checkOutput("sat_flush_E", {28'b0, flush_cnt}, 32'hE);
    end
    checkOutput("sat_flush_end", {28'b0, flush_cnt}, 32'hF);
    checkOutput("sat_stall_keep", {28'b0, stall_cnt}, 32'hF);

    // Reset while stalling and flushing
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0BAD_CAFE, 32'h84);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h90, 32'h0BAD_CAFE, 32'h94);
    stepCycle();
    checkOutput("mr_pcF",      pcF,    32'h0);
    checkOutput("mr_instrD",   instrD, 32'h0);
    checkOutput("mr_validD",   {31'b0, validD}, 32'h0);
    checkOutput("mr_validE",   {31'b0, validE}, 32'h0);
    checkOutput("mr_stallcnt", {28'b0, stall_cnt}, 32'h0);
    checkOutput("mr_flushcnt", {28'b0, flush_cnt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
